// File: rtl/proc_pkg.sv
// rtl/proc_pkg.sv - shared state encodings, opcodes and PC helpers for the sequencer
package proc_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FETCH   = 3'd1,
    S_DECODE  = 3'd2,
    S_EXEC    = 3'd3,
    S_WAIT_MD = 3'd4,
    S_WB      = 3'd5,
    S_HALT    = 3'd6,
    S_ILLEGAL = 3'd7
  } state_t;

  localparam logic [3:0] OP_MUL  = 4'd6;
  localparam logic [3:0] OP_DIV  = 4'd7;
  localparam logic [3:0] OP_JMP  = 4'd12;
  localparam logic [3:0] OP_JZ   = 4'd13;
  localparam logic [3:0] OP_JN   = 4'd14;
  localparam logic [3:0] OP_HALT = 4'd15;

  localparam int SR_Z = 0;
  localparam int SR_N = 1;

  function automatic logic [7:0] seq_pc(input logic [7:0] pc, input int prog_len);
    if (int'(pc) == prog_len - 1) return 8'd0;
    return pc + 8'd1;
  endfunction

  // Target wraps mod 256 first; anything beyond the program restarts at slot 0.
  function automatic logic [7:0] jump_pc(input logic [7:0] pc, input logic [7:0] ofs,
                                         input int prog_len);
    logic [7:0] tgt;
    tgt = pc + ofs;
    if (int'(tgt) >= prog_len) return 8'd0;
    return tgt;
  endfunction

endpackage

// File: rtl/md_watchdog.sv
// rtl/md_watchdog.sv - cycle counter bounding the wait for a multiply/divide result
module md_watchdog #(
  parameter int MD_TIMEOUT = 32
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_reached
);

  logic [7:0] r_count;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= 8'd0;
    end else if (i_clr) begin
      r_count <= 8'd0;
    end else if (i_en) begin
      r_count <= r_count + 8'd1;
    end
  end

  // High during the cycle whose increment brings the count to MD_TIMEOUT.
  assign o_reached = (int'(r_count) >= MD_TIMEOUT - 1);

endmodule

// File: rtl/instr_sequencer.sv
// rtl/instr_sequencer.sv - multi-cycle fetch/decode/execute/writeback sequencer with PC
module instr_sequencer
  import proc_pkg::*;
#(
  parameter int PROG_LEN   = 16,
  parameter int MD_TIMEOUT = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        run,
  input  logic [3:0]  opcode,
  input  logic [8:0]  address,
  input  logic [15:0] sr,
  input  logic        md_done,
  output logic [7:0]  pc,
  output logic        ir_load,
  output logic        rf_we,
  output logic        md_start,
  output logic [2:0]  state,
  output logic        halted,
  output logic        md_err,
  output logic [15:0] retired
);

  state_t      r_state;
  state_t      w_next;
  logic [7:0]  r_pc;
  logic [7:0]  w_pc_next;
  logic        r_md_start;
  logic        r_md_err;
  logic [15:0] r_retired;
  logic        w_retire;
  logic        w_set_err;
  logic        w_wd_clr;
  logic        w_wd_en;
  logic        w_wd_reached;
  logic        w_taken;
  logic        w_is_md;
  logic        w_unused;

  assign w_unused = ^{address[8], sr[15:2]};
  assign w_is_md  = (opcode == OP_MUL) || (opcode == OP_DIV);

  md_watchdog #(.MD_TIMEOUT(MD_TIMEOUT)) u_md_watchdog (
    .i_clk     (clk),
    .i_rst_n   (reset),
    .i_clr     (w_wd_clr),
    .i_en      (w_wd_en),
    .o_reached (w_wd_reached)
  );

  always_comb begin
    w_next    = r_state;
    w_pc_next = r_pc;
    w_retire  = 1'b0;
    w_set_err = 1'b0;
    w_wd_clr  = 1'b0;
    w_wd_en   = 1'b0;
    w_taken   = 1'b0;
    case (r_state)
      S_IDLE:   if (run) w_next = S_FETCH;
      S_FETCH:  w_next = S_DECODE;
      S_DECODE: w_next = S_EXEC;
      S_EXEC: begin
        case (opcode)
          OP_HALT: begin
            w_retire = 1'b1;
            w_next   = S_HALT;
          end
          OP_JMP, OP_JZ, OP_JN: begin
            w_taken   = (opcode == OP_JMP) ||
                        ((opcode == OP_JZ) && sr[SR_Z]) ||
                        ((opcode == OP_JN) && sr[SR_N]);
            w_pc_next = w_taken ? jump_pc(r_pc, address[7:0], PROG_LEN)
                                : seq_pc(r_pc, PROG_LEN);
            w_retire  = 1'b1;
            w_next    = run ? S_FETCH : S_IDLE;
          end
          OP_MUL, OP_DIV: begin
            w_wd_clr = 1'b1;
            w_next   = S_WAIT_MD;
          end
          default: w_next = S_WB;
        endcase
      end
      S_WAIT_MD: begin
        w_wd_en = 1'b1;
        // A result arriving on the timeout cycle still counts as a success.
        if (md_done) begin
          w_next = S_WB;
        end else if (w_wd_reached) begin
          w_set_err = 1'b1;
          w_next    = S_HALT;
        end
      end
      S_WB: begin
        w_pc_next = seq_pc(r_pc, PROG_LEN);
        w_retire  = 1'b1;
        w_next    = run ? S_FETCH : S_IDLE;
      end
      S_HALT:  w_next = S_HALT;
      default: w_next = S_IDLE;
    endcase
  end

  // md_start is registered off DECODE so it lands in EXEC without an input-to-output path.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_pc       <= 8'd0;
      r_md_start <= 1'b0;
      r_md_err   <= 1'b0;
      r_retired  <= 16'd0;
    end else begin
      r_state    <= w_next;
      r_pc       <= w_pc_next;
      r_md_start <= (r_state == S_DECODE) && w_is_md;
      if (w_set_err) r_md_err <= 1'b1;
      if (w_retire) r_retired <= r_retired + 16'd1;
    end
  end

  assign pc       = r_pc;
  assign state    = r_state;
  assign ir_load  = (r_state == S_FETCH);
  assign rf_we    = (r_state == S_WB);
  assign md_start = r_md_start;
  assign halted   = (r_state == S_HALT);
  assign md_err   = r_md_err;
  assign retired  = r_retired;

endmodule
